wave_sequencer: RTL and testbench
=================================

Name: wave_sequencer

Overview:
Controller that sequences the team's 5-bit waveform generator through a programmed playlist of up to 4 segments. Each segment is a (wave select, repeat count) pair.
The block drives the generator's 2-bit wave select and changes it only on period boundaries, so the generator never sees a mid-period switch. A host writes the playlist, then starts playback, stops it gracefully, or loops it.

Parameters:
SQ_PERIOD, 20, clock cycles per square-wave period (select 2'b00)
SAW_PERIOD, 21, clock cycles per sawtooth period (select 2'b01)
TRI_PERIOD, 40, clock cycles per triangle period (select 2'b10)
SIL_PERIOD, 20, clock cycles per silence period (select 2'b11; generator outputs 0)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  playlist write strobe
cfg_addr  input  2  playlist entry index 0..3
cfg_wave  input  2  wave select stored in the entry
cfg_reps  input  4  periods to play; 0 marks end-of-list
loop_en  input  1  1: restart at entry 0 after end-of-list; 0: finish
start  input  1  single-cycle start pulse, honoured only in IDLE
stop  input  1  single-cycle graceful-stop request, honoured only in RUN
wave_choise  output  2  wave select to the generator
busy  output  1  high while in RUN
seg_idx  output  2  index of the entry now playing
period_done  output  1  one-cycle pulse on the last cycle of each period
done  output  1  one-cycle pulse when playback ends
cfg_err  output  1  one-cycle pulse when cfg_we is asserted while busy

Behaviour:
- Reset (async, rst_n=0):
  - wave_choise=2'b11, busy=0, seg_idx=0, period_done=0, done=0, cfg_err=0.
  - All 4 entries cleared to wave=2'b11, reps=0.
  - period_cnt=0, rep_cnt=0, stop_pend=0, state=IDLE.
- Storage: 4 entries x 6 bits. period_cnt is 6 bits; rep_cnt is 4 bits.
- Config writes:
  - In IDLE, cfg_we writes the entry at the clock edge.
  - In RUN, the write is dropped and cfg_err pulses on the next cycle.
- IDLE state:
  - wave_choise=2'b11.
  - start with entry0.reps==0: stay IDLE; done pulses the next cycle.
  - start with entry0.reps!=0: at the next edge go to RUN with wave_choise=entry0.wave, seg_idx=0, rep_cnt=entry0.reps, period_cnt=0, busy=1.
  - Latency from start to the new wave select is 1 cycle.
- RUN state:
  - P is the period parameter selected by the current wave_choise.
  - period_cnt increments each cycle.
  - When period_cnt==P-1: period_done=1 that cycle, and at the edge period_cnt<=0 and rep_cnt<=rep_cnt-1.
- Boundary handling (period_cnt==P-1), in priority order:
  1. stop_pend=1, or stop asserted this cycle: go to IDLE, wave_choise<=2'b11, busy<=0, done pulses, stop_pend<=0.
  2. rep_cnt==1: advance to the next entry n=seg_idx+1.
     - If n==4 (the index wraps to 0) or entry[n].reps==0, end-of-list is reached.
     - At end-of-list with loop_en=1 and entry0.reps!=0: load entry0.
     - At end-of-list otherwise: go to IDLE with a done pulse.
     - When not at end-of-list: load entry n.
     - Loading means wave_choise, seg_idx and rep_cnt update at the same edge as period_cnt<=0, so there are no gap cycles.
  3. Otherwise: same entry, next period.
- stop asserted in RUN off the boundary sets stop_pend. Playback ends at the current period's boundary.
- start in RUN is ignored. stop in IDLE is ignored.
- A period_done pulse and a done pulse never coincide: done is registered one cycle after the boundary.
- Reset mid-operation: immediate return to reset values. The playlist is lost.
- Entries with wave=2'b11 play silence for reps x SIL_PERIOD cycles.

Test Plan:
- Single segment: write entry0={00,reps=2}, entry1.reps=0, pulse start at cycle 0 -> wave_choise=00 from cycle 1 to 40; period_done at cycles 20 and 40; wave_choise=11 and busy=0 at cycle 41; done=1 at cycle 41.
- Chained: entry0={01,1}, entry1={10,2}, entry2.reps=0 -> wave_choise=01 for 21 cycles, then 10 for 80 cycles with no gap; seg_idx goes 0 then 1; done pulses once.
- Loop: same list with loop_en=1 -> after the entry1 boundary, wave_choise returns to 01 and seg_idx=0; busy stays 1 through 3 full loops.
- Graceful stop: entry0={10,15}, pulse stop at cycle 5 of period 3 -> playback continues to the period-3 boundary (cycle 120), then IDLE with done; exactly 3 period_done pulses.
- Illegal write while busy: cfg_we during RUN -> entry unchanged on read-back via replay; cfg_err pulses once.
- Reset mid-RUN: drop rst_n asynchronously mid-period -> outputs go to reset values immediately; a later start with no writes produces only a done pulse.

Source files
------------

// File: rtl/wave_sequencer.sv
// Playlist sequencer for the 5-bit waveform generator.
// Wave select changes only on period boundaries; up to 4 (wave, reps) segments.
module wave_sequencer #(
    parameter int unsigned SQ_PERIOD  = 20,
    parameter int unsigned SAW_PERIOD = 21,
    parameter int unsigned TRI_PERIOD = 40,
    parameter int unsigned SIL_PERIOD = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [1:0] cfg_wave,
    input  logic [3:0] cfg_reps,
    input  logic       loop_en,
    input  logic       start,
    input  logic       stop,
    output logic [1:0] wave_choise,
    output logic       busy,
    output logic [1:0] seg_idx,
    output logic       period_done,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] wave_q [4];
    logic [3:0] reps_q [4];
    logic [1:0] wsel_q, wsel_d;
    logic [1:0] seg_q, seg_d;
    logic [3:0] rep_q, rep_d;
    logic [5:0] pcnt_q, pcnt_d;
    logic       stop_q, stop_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [5:0] plast;
    logic       bnd;
    logic [1:0] nxt;
    logic       eol;

    always_comb begin
        plast = 6'(SIL_PERIOD - 1);
        unique case (wsel_q)
            2'b00: plast = 6'(SQ_PERIOD - 1);
            2'b01: plast = 6'(SAW_PERIOD - 1);
            2'b10: plast = 6'(TRI_PERIOD - 1);
            2'b11: plast = 6'(SIL_PERIOD - 1);
        endcase
    end

    assign bnd = (state_q == RUN) && (pcnt_q == plast);
    assign nxt = seg_q + 2'd1;
    // Index wrap past entry 3 counts as end-of-list.
    assign eol = (seg_q == 2'd3) || (reps_q[nxt] == 4'd0);

    always_comb begin
        state_d = state_q;
        wsel_d  = wsel_q;
        seg_d   = seg_q;
        rep_d   = rep_q;
        pcnt_d  = pcnt_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        err_d   = cfg_we && (state_q == RUN);
        unique case (state_q)
            IDLE: begin
                wsel_d = 2'b11;
                stop_d = 1'b0;
                if (start) begin
                    if (reps_q[0] == 4'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        wsel_d  = wave_q[0];
                        seg_d   = 2'd0;
                        rep_d   = reps_q[0];
                        pcnt_d  = 6'd0;
                    end
                end
            end
            RUN: begin
                pcnt_d = pcnt_q + 6'd1;
                if (!bnd && stop) begin
                    stop_d = 1'b1;
                end
                if (bnd) begin
                    pcnt_d = 6'd0;
                    rep_d  = rep_q - 4'd1;
                    if (stop_q || stop) begin
                        state_d = IDLE;
                        wsel_d  = 2'b11;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else if (rep_q == 4'd1) begin
                        if (!eol) begin
                            wsel_d = wave_q[nxt];
                            seg_d  = nxt;
                            rep_d  = reps_q[nxt];
                        end else if (loop_en && reps_q[0] != 4'd0) begin
                            wsel_d = wave_q[0];
                            seg_d  = 2'd0;
                            rep_d  = reps_q[0];
                        end else begin
                            state_d = IDLE;
                            wsel_d  = 2'b11;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wsel_q  <= 2'b11;
            seg_q   <= 2'd0;
            rep_q   <= 4'd0;
            pcnt_q  <= 6'd0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wsel_q  <= wsel_d;
            seg_q   <= seg_d;
            rep_q   <= rep_d;
            pcnt_q  <= pcnt_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wave_q[i] <= 2'b11;
                reps_q[i] <= 4'd0;
            end
        end else if (cfg_we && state_q == IDLE) begin
            wave_q[cfg_addr] <= cfg_wave;
            reps_q[cfg_addr] <= cfg_reps;
        end
    end

    assign wave_choise = wsel_q;
    assign busy        = (state_q == RUN);
    assign seg_idx     = seg_q;
    assign period_done = bnd;
    assign done        = done_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench for wave_sequencer: expected pulse events are queued
// by the stimulus and matched by a negedge monitor.
module tb_wave_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [1:0] cfg_wave = 2'd0;
    logic [3:0] cfg_reps = 4'd0;
    logic       loop_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] wave_choise;
    logic       busy;
    logic [1:0] seg_idx;
    logic       period_done;
    logic       done;
    logic       cfg_err;

    wave_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wave(cfg_wave), .cfg_reps(cfg_reps), .loop_en(loop_en),
        .start(start), .stop(stop), .wave_choise(wave_choise),
        .busy(busy), .seg_idx(seg_idx), .period_done(period_done),
        .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // kind: 0 period_done, 1 done, 2 cfg_err; seg < 0 means don't care
    typedef struct {
        int         kind;
        int         cyc;
        logic [1:0] wave;
        int         seg;
        logic       busy;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic exp_ev(int k, int c, logic [1:0] w, int s, logic b);
        ev_t e;
        e = '{k, c, w, s, b};
        sb.push_back(e);
    endtask

    task automatic pop(int k);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d required none", k, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc || wave_choise !== e.wave ||
                busy !== e.busy || (e.seg >= 0 && seg_idx !== 2'(e.seg))) begin
                failures++;
                $display("FAIL event actual kind=%0d cyc=%0d wave=%b busy=%b seg=%0d required kind=%0d cyc=%0d wave=%b busy=%b seg=%0d",
                         k, cyc, wave_choise, busy, seg_idx,
                         e.kind, e.cyc, e.wave, e.busy, e.seg);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (period_done) pop(0);
            if (done) pop(1);
            if (cfg_err) pop(2);
        end
    end

    task automatic wr(logic [1:0] a, logic [1:0] w, logic [3:0] r);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wave = w;
        cfg_reps = r;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic go(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_wave"}, int'(wave_choise), 3);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_seg"}, int'(seg_idx), 0);
        chk({tag, "_pd"}, int'(period_done), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(cfg_err), 0);
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;

        // single segment: square x2
        wr(2'd0, 2'b00, 4'd2);
        go(t0);
        chk("single_wave", int'(wave_choise), 0);
        chk("single_busy", int'(busy), 1);
        exp_ev(0, t0 + 20, 2'b00, 0, 1'b1);
        exp_ev(0, t0 + 40, 2'b00, 0, 1'b1);
        exp_ev(1, t0 + 41, 2'b11, -1, 1'b0);
        wait_until(t0 + 45);

        // chained: saw x1 then triangle x2
        wr(2'd0, 2'b01, 4'd1);
        wr(2'd1, 2'b10, 4'd2);
        wr(2'd2, 2'b11, 4'd0);
        go(t0);
        exp_ev(0, t0 + 21, 2'b01, 0, 1'b1);
        exp_ev(0, t0 + 61, 2'b10, 1, 1'b1);
        exp_ev(0, t0 + 101, 2'b10, 1, 1'b1);
        exp_ev(1, t0 + 102, 2'b11, -1, 1'b0);
        wait_until(t0 + 22);
        chk("chain_wave_seg1", int'(wave_choise), 2);
        chk("chain_seg1", int'(seg_idx), 1);
        wait_until(t0 + 105);

        // loop three times, then stop during the fourth pass
        loop_en = 1'b1;
        go(t0);
        for (int k = 0; k < 3; k++) begin
            exp_ev(0, t0 + 101 * k + 21, 2'b01, 0, 1'b1);
            exp_ev(0, t0 + 101 * k + 61, 2'b10, 1, 1'b1);
            exp_ev(0, t0 + 101 * k + 101, 2'b10, 1, 1'b1);
        end
        exp_ev(0, t0 + 324, 2'b01, 0, 1'b1);
        exp_ev(1, t0 + 325, 2'b11, -1, 1'b0);
        wait_until(t0 + 102);
        chk("loop_wave", int'(wave_choise), 1);
        chk("loop_seg", int'(seg_idx), 0);
        wait_until(t0 + 250);
        chk("loop_busy", int'(busy), 1);
        wait_until(t0 + 308);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        loop_en = 1'b0;
        wait_until(t0 + 328);

        // graceful stop in period 3 of a 15-rep triangle
        wr(2'd0, 2'b10, 4'd15);
        go(t0);
        exp_ev(0, t0 + 40, 2'b10, 0, 1'b1);
        exp_ev(0, t0 + 80, 2'b10, 0, 1'b1);
        exp_ev(0, t0 + 120, 2'b10, 0, 1'b1);
        exp_ev(1, t0 + 121, 2'b11, -1, 1'b0);
        wait_until(t0 + 85);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_until(t0 + 123);
        chk("stop_busy", int'(busy), 0);
        chk("stop_wave", int'(wave_choise), 3);

        // write while busy is rejected; replay shows the entry unchanged
        wr(2'd0, 2'b00, 4'd1);
        wr(2'd1, 2'b11, 4'd1);
        for (int r = 0; r < 2; r++) begin
            go(t0);
            exp_ev(0, t0 + 20, 2'b00, 0, 1'b1);
            exp_ev(0, t0 + 40, 2'b11, 1, 1'b1);
            exp_ev(1, t0 + 41, 2'b11, -1, 1'b0);
            if (r == 0) begin
                exp_ev(2, t0 + 6, 2'b00, 0, 1'b1);
                sb.sort() with (item.cyc);
                wait_until(t0 + 5);
                cfg_we = 1'b1;
                cfg_addr = 2'd0;
                cfg_wave = 2'b10;
                cfg_reps = 4'd3;
                @(negedge clk);
                cfg_we = 1'b0;
            end
            wait_until(t0 + 45);
        end

        // asynchronous reset mid-period
        go(t0);
        wait_until(t0 + 10);
        #2 rst_n = 1'b0;
        #1 chk_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        go(t0);
        exp_ev(1, t0 + 1, 2'b11, 0, 1'b0);
        chk("empty_busy", int'(busy), 0);
        wait_until(t0 + 5);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
